// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini-SRC style datapath.
//   - 5-bit instruction opcodes (IR[31:27])
//   - C2 branch condition codes (IR[20:19])
//   - bus source identifiers, listed in descending bus priority
//   - con_eval: evaluates a C2 condition against a bus value
package cpu_pkg;

    localparam logic [4:0] OP_LDW    = 5'b00000;
    localparam logic [4:0] OP_LDWI   = 5'b00001;
    localparam logic [4:0] OP_STW    = 5'b00010;
    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00100;
    localparam logic [4:0] OP_SHR    = 5'b00101;
    localparam logic [4:0] OP_SHL    = 5'b00110;
    localparam logic [4:0] OP_ROR    = 5'b00111;
    localparam logic [4:0] OP_ROL    = 5'b01000;
    localparam logic [4:0] OP_AND    = 5'b01001;
    localparam logic [4:0] OP_OR     = 5'b01010;
    localparam logic [4:0] OP_ADDI   = 5'b01011;
    localparam logic [4:0] OP_ANDI   = 5'b01100;
    localparam logic [4:0] OP_ORI    = 5'b01101;
    localparam logic [4:0] OP_MUL    = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_NEG    = 5'b10000;
    localparam logic [4:0] OP_NOT    = 5'b10001;
    localparam logic [4:0] OP_BRANCH = 5'b10010;
    localparam logic [4:0] OP_JR     = 5'b10011;
    localparam logic [4:0] OP_JAL    = 5'b10100;
    localparam logic [4:0] OP_IN     = 5'b10101;
    localparam logic [4:0] OP_OUT    = 5'b10110;
    localparam logic [4:0] OP_MFHI   = 5'b10111;
    localparam logic [4:0] OP_MFLO   = 5'b11000;
    localparam logic [4:0] OP_NOP    = 5'b11001;
    localparam logic [4:0] OP_HALT   = 5'b11010;

    localparam logic [1:0] C2_ZERO    = 2'b00;
    localparam logic [1:0] C2_NONZERO = 2'b01;
    localparam logic [1:0] C2_POS     = 2'b10;
    localparam logic [1:0] C2_NEG     = 2'b11;

    // Enumeration order matches bus priority, highest first.
    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_MDR,
        SRC_PC,
        SRC_Y,
        SRC_ZLO,
        SRC_ZHI,
        SRC_LO,
        SRC_HI,
        SRC_IN,
        SRC_C,
        SRC_REG,
        SRC_BA
    } bus_src_e;

    function automatic logic con_eval(input logic [1:0] c2, input logic [31:0] v);
        case (c2)
            C2_ZERO:    return (v == 32'd0);
            C2_NONZERO: return (v != 32'd0);
            C2_POS:     return !v[31] && (v != 32'd0);
            default:    return v[31];
        endcase
    endfunction

endpackage

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU.
//   a      : operand A (Y register)
//   b      : operand B (bus)
//   opcode : IR[31:27]
//   cin    : carry-in for the add-type operations
//   result : 64-bit result; upper half is the mul high word / div remainder,
//            otherwise the sign extension of the lower half
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  opcode,
    input  logic        cin,
    output logic [63:0] result
);

    logic [4:0]         sh;
    logic [31:0]        lo;
    logic signed [63:0] a64;
    logic signed [63:0] b64;
    logic signed [63:0] prod;
    logic signed [32:0] a33;
    logic signed [32:0] b33;
    logic signed [32:0] quo;
    logic signed [32:0] rem;
    logic               unused_div;

    assign sh   = b[4:0];
    assign a64  = {{32{a[31]}}, a};
    assign b64  = {{32{b[31]}}, b};
    assign prod = a64 * b64;

    // Dividing in 33 bits keeps -2^31 / -1 well defined; the quotient simply
    // wraps back to 0x80000000 when truncated.
    assign a33 = {a[31], a};
    assign b33 = {b[31], b};
    assign quo = (b == 32'd0) ? 33'sd0 : a33 / b33;
    assign rem = (b == 32'd0) ? 33'sd0 : a33 % b33;
    assign unused_div = quo[32] ^ rem[32];

    always_comb begin
        lo = b;
        case (opcode)
            OP_LDW, OP_LDWI, OP_STW, OP_ADD, OP_ADDI, OP_BRANCH:
                lo = a + b + {31'd0, cin};
            OP_SUB:          lo = a - b;
            OP_SHR:          lo = a >> sh;
            OP_SHL:          lo = a << sh;
            // A shift by 32 yields 0, so rotate-by-0 falls out correctly.
            OP_ROR:          lo = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
            OP_ROL:          lo = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
            OP_AND, OP_ANDI: lo = a & b;
            OP_OR, OP_ORI:   lo = a | b;
            OP_NEG:          lo = 32'd0 - b;
            OP_NOT:          lo = ~b;
            default:         lo = b;
        endcase

        result = {{32{lo[31]}}, lo};
        if (opcode == OP_MUL) begin
            result = prod;
        end else if (opcode == OP_DIV) begin
            result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem[31:0], quo[31:0]};
        end
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit datapath: 16 GPRs, PC, IR, MAR, MDR, HI, LO, Y, 64-bit Z,
// ALU, select-and-encode, CON flip-flop, RAM and I/O ports. All sequencing
// comes from external strobes.
// Ports:
//   Clock, Clear (async, active low)
//   load strobes : *_enable, ZHighIn, ZLowIn, R_in, CONin, IncPC, RAM_write
//   bus drivers  : MDRout, PCout, Yout, ZLowout, ZHighout, LOout, HIout,
//                  InPortout, Cout, R_out, BAout
//   selects      : Gra, Grb, Grc, MDR_read, Cin
//   data         : InPort_input, Mdatain -> OutPort_output, CON_out
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int RAM_DEPTH   = 512,
    parameter int USE_EXT_MEM = 0
) (
    input  logic        Clock,
    input  logic        Clear,
    output logic [31:0] OutPort_output,
    input  logic        IncPC,
    input  logic        CONin,
    input  logic        RAM_write,
    input  logic        MDR_enable,
    input  logic        MDR_read,
    input  logic        MAR_enable,
    input  logic        IR_enable,
    input  logic        HI_enable,
    input  logic        LO_enable,
    input  logic        Y_enable,
    input  logic        PC_enable,
    input  logic        OutPort_enable,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        MDRout,
    input  logic        InPortout,
    input  logic        PCout,
    input  logic        Yout,
    input  logic        ZLowout,
    input  logic        ZHighout,
    input  logic        LOout,
    input  logic        HIout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        R_in,
    input  logic        R_out,
    input  logic        BAout,
    input  logic        Cout,
    input  logic        Cin,
    input  logic [31:0] InPort_input,
    input  logic [31:0] Mdatain,
    output logic        CON_out
);

    localparam int AW = $clog2(RAM_DEPTH);

    logic [31:0] gpr [16];
    logic [31:0] pc, ir, mar, mdr, hi, lo, y, z_hi, z_lo, in_port, out_port;
    logic        con;
    logic [31:0] mem [RAM_DEPTH];

    logic [31:0] bus;
    bus_src_e    src;
    logic [3:0]  sel;
    logic [31:0] c_sext;
    logic [31:0] mem_rdata;
    logic [63:0] alu_res;
    logic        unused_mar;

    assign unused_mar = ^mar[31:AW];

    // Select-and-encode: enabled IR fields are OR-ed together.
    assign sel = (Gra ? ir[26:23] : 4'd0)
               | (Grb ? ir[22:19] : 4'd0)
               | (Grc ? ir[18:15] : 4'd0);

    assign c_sext    = {{13{ir[18]}}, ir[18:0]};
    assign mem_rdata = (USE_EXT_MEM != 0) ? Mdatain : mem[mar[AW-1:0]];

    always_comb begin
        src = SRC_NONE;
        if (MDRout)         src = SRC_MDR;
        else if (PCout)     src = SRC_PC;
        else if (Yout)      src = SRC_Y;
        else if (ZLowout)   src = SRC_ZLO;
        else if (ZHighout)  src = SRC_ZHI;
        else if (LOout)     src = SRC_LO;
        else if (HIout)     src = SRC_HI;
        else if (InPortout) src = SRC_IN;
        else if (Cout)      src = SRC_C;
        else if (R_out)     src = SRC_REG;
        else if (BAout)     src = SRC_BA;
    end

    always_comb begin
        bus = 32'd0;
        case (src)
            SRC_MDR: bus = mdr;
            SRC_PC:  bus = pc;
            SRC_Y:   bus = y;
            SRC_ZLO: bus = z_lo;
            SRC_ZHI: bus = z_hi;
            SRC_LO:  bus = lo;
            SRC_HI:  bus = hi;
            SRC_IN:  bus = in_port;
            SRC_C:   bus = c_sext;
            SRC_REG: bus = gpr[sel];
            // Base-address read: R0 stands for a literal zero.
            SRC_BA:  bus = (sel == 4'd0) ? 32'd0 : gpr[sel];
            default: bus = 32'd0;
        endcase
    end

    cpu_alu u_alu (
        .a      (y),
        .b      (bus),
        .opcode (ir[31:27]),
        .cin    (Cin),
        .result (alu_res)
    );

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) gpr[i] <= 32'd0;
            pc       <= 32'd0;
            ir       <= 32'd0;
            mar      <= 32'd0;
            mdr      <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            y        <= 32'd0;
            z_hi     <= 32'd0;
            z_lo     <= 32'd0;
            in_port  <= 32'd0;
            out_port <= 32'd0;
            con      <= 1'b0;
        end else begin
            if (R_in) gpr[sel] <= bus;
            if (IncPC)          pc <= pc + 32'd1;
            else if (PC_enable) pc <= bus;
            if (IR_enable)  ir  <= bus;
            if (MAR_enable) mar <= bus;
            if (MDR_enable) mdr <= MDR_read ? mem_rdata : bus;
            if (HI_enable)  hi  <= bus;
            if (LO_enable)  lo  <= bus;
            if (Y_enable)   y   <= bus;
            if (ZHighIn)    z_hi <= alu_res[63:32];
            if (ZLowIn)     z_lo <= alu_res[31:0];
            in_port <= InPort_input;
            if (OutPort_enable) out_port <= bus;
            if (CONin) con <= con_eval(ir[20:19], bus);
        end
    end

    // RAM contents survive Clear, so the array sits outside the reset block.
    always_ff @(posedge Clock) begin
        if (RAM_write) mem[mar[AW-1:0]] <= mdr;
    end

    assign OutPort_output = out_port;
    assign CON_out        = con;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath. Two instances share all inputs: dut uses internal
// RAM, dut_x takes memory data from Mdatain.
module tb_cpu_datapath;

    logic        Clock, Clear;
    logic        IncPC, CONin, RAM_write, MDR_enable, MDR_read, MAR_enable;
    logic        IR_enable, HI_enable, LO_enable, Y_enable, PC_enable, OutPort_enable;
    logic        ZHighIn, ZLowIn, MDRout, InPortout, PCout, Yout, ZLowout, ZHighout;
    logic        LOout, HIout, Gra, Grb, Grc, R_in, R_out, BAout, Cout, Cin;
    logic [31:0] InPort_input, Mdatain;
    logic [31:0] out_port, out_port_x;
    logic        con, con_x;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    cpu_datapath #(.RAM_DEPTH(512), .USE_EXT_MEM(0)) dut (
        .Clock(Clock), .Clear(Clear), .OutPort_output(out_port), .IncPC(IncPC),
        .CONin(CONin), .RAM_write(RAM_write), .MDR_enable(MDR_enable), .MDR_read(MDR_read),
        .MAR_enable(MAR_enable), .IR_enable(IR_enable), .HI_enable(HI_enable),
        .LO_enable(LO_enable), .Y_enable(Y_enable), .PC_enable(PC_enable),
        .OutPort_enable(OutPort_enable), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .MDRout(MDRout), .InPortout(InPortout), .PCout(PCout), .Yout(Yout),
        .ZLowout(ZLowout), .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .BAout(BAout),
        .Cout(Cout), .Cin(Cin), .InPort_input(InPort_input), .Mdatain(Mdatain),
        .CON_out(con)
    );

    cpu_datapath #(.RAM_DEPTH(512), .USE_EXT_MEM(1)) dut_x (
        .Clock(Clock), .Clear(Clear), .OutPort_output(out_port_x), .IncPC(IncPC),
        .CONin(CONin), .RAM_write(RAM_write), .MDR_enable(MDR_enable), .MDR_read(MDR_read),
        .MAR_enable(MAR_enable), .IR_enable(IR_enable), .HI_enable(HI_enable),
        .LO_enable(LO_enable), .Y_enable(Y_enable), .PC_enable(PC_enable),
        .OutPort_enable(OutPort_enable), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .MDRout(MDRout), .InPortout(InPortout), .PCout(PCout), .Yout(Yout),
        .ZLowout(ZLowout), .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .BAout(BAout),
        .Cout(Cout), .Cin(Cin), .InPort_input(InPort_input), .Mdatain(Mdatain),
        .CON_out(con_x)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        longint      sa, sb, q, r;
        logic [63:0] t, qv, rv;
        logic [31:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd18: res = a + b + 32'(cin);
            5'd4:  res = a - b;
            5'd5:  res = a >> b[4:0];
            5'd6:  res = a << b[4:0];
            5'd7:  begin t = {a, a} >> b[4:0]; res = t[31:0]; end
            5'd8:  begin t = {a, a} << b[4:0]; res = t[63:32]; end
            5'd9, 5'd12:  res = a & b;
            5'd10, 5'd13: res = a | b;
            5'd14: return 64'(sa * sb);
            5'd15: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            5'd16: res = -b;
            5'd17: res = ~b;
            default: res = b;
        endcase
        return {{32{res[31]}}, res};
    endfunction

    function automatic logic ref_con(input logic [1:0] c2, input logic [31:0] v);
        case (c2)
            2'd0:    return v == 32'd0;
            2'd1:    return v != 32'd0;
            2'd2:    return $signed(v) > 0;
            default: return $signed(v) < 0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clr_ctrl();
        IncPC = 0; CONin = 0; RAM_write = 0; MDR_enable = 0; MDR_read = 0;
        MAR_enable = 0; IR_enable = 0; HI_enable = 0; LO_enable = 0; Y_enable = 0;
        PC_enable = 0; OutPort_enable = 0; ZHighIn = 0; ZLowIn = 0; MDRout = 0;
        InPortout = 0; PCout = 0; Yout = 0; ZLowout = 0; ZHighout = 0; LOout = 0;
        HIout = 0; Gra = 0; Grb = 0; Grc = 0; R_in = 0; R_out = 0; BAout = 0;
        Cout = 0; Cin = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        clr_ctrl();
    endtask

    task automatic do_reset();
        Clear = 1'b0;
        tick();
        Clear = 1'b1;
        tick();
    endtask

    // InPort register samples every clock; one edge makes v available.
    task automatic load_in(input logic [31:0] v);
        InPort_input = v;
        @(posedge Clock);
        #1;
    endtask

    task automatic set_ir(input logic [31:0] v);
        load_in(v);
        InPortout = 1; IR_enable = 1;
        tick();
    endtask

    task automatic write_gpr(input logic [3:0] k, input logic [31:0] v);
        set_ir({5'b11001, k, 23'd0});
        load_in(v);
        InPortout = 1; Gra = 1; R_in = 1;
        tick();
    endtask

    // Copies the current bus value into the output port register.
    task automatic read_out();
        OutPort_enable = 1;
        tick();
    endtask

    task automatic set_src(input int j);
        case (j)
            0: MDRout = 1;
            1: PCout = 1;
            2: Yout = 1;
            3: ZLowout = 1;
            4: ZHighout = 1;
            5: LOout = 1;
            6: HIout = 1;
            7: InPortout = 1;
            8: Cout = 1;
            default: begin Gra = 1; R_out = 1; end
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] v;
        n_checks++;
        if (out_port !== 32'd0) begin n_err++; $display("FAIL reset_outport: got %h want 0", out_port); end
        n_checks++;
        if (con !== 1'b0) begin n_err++; $display("FAIL reset_con: got %b want 0", con); end

        write_gpr(4'd3, 32'hCAFE_0003);
        set_ir({5'b11001, 27'd0});
        CONin = 1;
        tick();
        n_checks++;
        if (con !== 1'b1) begin n_err++; $display("FAIL con_zero_idle: got %b want 1", con); end

        v = $urandom() | 32'h1;
        load_in(v);
        InPortout = 1; Y_enable = 1; HI_enable = 1; LO_enable = 1; PC_enable = 1;
        MDR_enable = 1; ZLowIn = 1; ZHighIn = 1; OutPort_enable = 1;
        tick();
        n_checks++;
        if (out_port !== v) begin n_err++; $display("FAIL multi_load_out: got %h want %h", out_port, v); end

        #2;
        Clear = 1'b0;
        #1;
        n_checks++;
        if (out_port !== 32'd0) begin n_err++; $display("FAIL async_clear_out: got %h want 0", out_port); end
        n_checks++;
        if (con !== 1'b0) begin n_err++; $display("FAIL async_clear_con: got %b want 0", con); end
        Clear = 1'b1;
        @(posedge Clock);
        #1;

        for (int j = 0; j < 7; j++) begin
            set_src(j);
            read_out();
            n_checks++;
            if (out_port !== 32'd0) begin n_err++; $display("FAIL reset_reg src=%0d: got %h want 0", j, out_port); end
        end
        set_ir({5'b11001, 4'd3, 23'd0});
        Gra = 1; R_out = 1;
        read_out();
        n_checks++;
        if (out_port !== 32'd0) begin n_err++; $display("FAIL reset_r3: got %h want 0", out_port); end
    endtask

    task automatic test_ldi();
        do_reset();
        write_gpr(4'd0, 32'h0000_ABCD);
        Mdatain = 32'h0880_0007;
        PCout = 1; MAR_enable = 1; IncPC = 1;
        tick();
        PCout = 1;
        read_out();
        n_checks++;
        if (out_port_x !== 32'd1) begin n_err++; $display("FAIL ldi_pc: got %h want 1", out_port_x); end
        MDR_read = 1; MDR_enable = 1;
        tick();
        MDRout = 1;
        read_out();
        n_checks++;
        if (out_port_x !== 32'h0880_0007) begin n_err++; $display("FAIL ldi_mdr: got %h want 08800007", out_port_x); end
        MDRout = 1; IR_enable = 1;
        tick();
        Grb = 1; BAout = 1; Y_enable = 1;
        tick();
        Yout = 1;
        read_out();
        n_checks++;
        if (out_port_x !== 32'd0) begin n_err++; $display("FAIL ldi_y_ba_r0: got %h want 0", out_port_x); end
        Cout = 1; ZLowIn = 1; ZHighIn = 1;
        tick();
        ZLowout = 1; Gra = 1; R_in = 1;
        tick();
        ZHighout = 1;
        read_out();
        n_checks++;
        if (out_port_x !== 32'd0) begin n_err++; $display("FAIL ldi_zhi: got %h want 0", out_port_x); end
        set_ir({5'b11001, 4'd1, 23'd0});
        Gra = 1; R_out = 1;
        read_out();
        n_checks++;
        if (out_port_x !== 32'd7) begin n_err++; $display("FAIL ldi_r1: got %h want 7", out_port_x); end
        set_ir({5'b11001, 4'd0, 23'd0});
        Gra = 1; R_out = 1;
        read_out();
        n_checks++;
        if (out_port_x !== 32'h0000_ABCD) begin n_err++; $display("FAIL r0_rout: got %h want 0000abcd", out_port_x); end
    endtask

    task automatic test_alu();
        logic [4:0]  op;
        logic [31:0] a, b;
        logic        c;
        logic [63:0] exp;
        logic [4:0]  d_op [5] = '{5'd14, 5'd15, 5'd15, 5'd15, 5'd3};
        logic [31:0] d_a  [5] = '{32'hFFFF_FFFD, 32'd17, 32'hFFFF_FFEF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] d_b  [5] = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 45; i++) begin
            if (i < 5) begin
                op = d_op[i]; a = d_a[i]; b = d_b[i]; c = (i == 4);
            end else begin
                op = 5'($urandom_range(0, 31));
                a  = $urandom();
                b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
                c  = (op == 5'd3 || op == 5'd11) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            exp = ref_alu(op, a, b, c);
            set_ir({op, 27'($urandom())});
            load_in(a);
            InPortout = 1; Y_enable = 1;
            tick();
            load_in(b);
            InPortout = 1; Cin = c; ZLowIn = 1; ZHighIn = 1;
            tick();
            ZLowout = 1;
            read_out();
            n_checks++;
            if (out_port !== exp[31:0]) begin
                n_err++; $display("FAIL alu_lo op=%0d a=%h b=%h: got %h want %h", op, a, b, out_port, exp[31:0]);
            end
            ZHighout = 1;
            read_out();
            n_checks++;
            if (out_port !== exp[63:32]) begin
                n_err++; $display("FAIL alu_hi op=%0d a=%h b=%h: got %h want %h", op, a, b, out_port, exp[63:32]);
            end
        end
    endtask

    task automatic test_mem();
        logic [31:0] addr, data, mar_v;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin addr = 32'h1F4; data = 32'hDEAD_BEEF; end
                1: begin addr = 32'd0;   data = $urandom(); end
                2: begin addr = 32'd511; data = $urandom(); end
                default: begin addr = 32'(16 + (i - 3) * 50 + $urandom_range(0, 40)); data = $urandom(); end
            endcase
            mar_v = ($urandom() & 32'hFFFF_FE00) | addr;
            load_in(mar_v);
            InPortout = 1; MAR_enable = 1;
            tick();
            load_in(data);
            InPortout = 1; MDR_enable = 1;
            tick();
            RAM_write = 1;
            tick();
            exp_q.push_back(data);
            addr_q.push_back(addr);
        end
        load_in(32'd0);
        InPortout = 1; MDR_enable = 1;
        tick();
        while (exp_q.size() > 0) begin
            data = exp_q.pop_front();
            addr = addr_q.pop_front();
            load_in(($urandom() & 32'hFFFF_FE00) | addr);
            InPortout = 1; MAR_enable = 1;
            tick();
            MDR_read = 1; MDR_enable = 1;
            tick();
            MDRout = 1;
            read_out();
            n_checks++;
            if (out_port !== data) begin n_err++; $display("FAIL mem_read addr=%0d: got %h want %h", addr, out_port, data); end
        end
    endtask

    task automatic test_con();
        logic [1:0]  c2;
        logic [31:0] v;
        logic        exp;
        for (int i = 0; i < 15; i++) begin
            case (i)
                0: begin c2 = 2'b01; v = 32'd0; end
                1: begin c2 = 2'b01; v = 32'd4; end
                2: begin c2 = 2'b11; v = 32'h8000_0000; end
                default: begin
                    c2 = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0: v = 32'd0;
                        1: v = 32'h8000_0000 | $urandom();
                        2: v = 32'($urandom_range(1, 100));
                        default: v = $urandom();
                    endcase
                end
            endcase
            exp = ref_con(c2, v);
            set_ir({5'b10010, 4'($urandom()), 2'b00, c2, 19'($urandom())});
            load_in(v);
            InPortout = 1; CONin = 1;
            tick();
            n_checks++;
            if (con !== exp) begin n_err++; $display("FAIL con c2=%0d v=%h: got %b want %b", c2, v, con, exp); end
        end
    endtask

    task automatic test_bus_priority();
        logic [31:0] vals [10];
        logic [18:0] cfield;
        for (int j = 0; j < 10; j++) vals[j] = $urandom();
        cfield   = 19'($urandom());
        vals[4]  = {32{vals[3][31]}};
        vals[8]  = {{13{cfield[18]}}, cfield};
        write_gpr(4'd5, vals[9]);
        set_ir({5'b11001, 4'd5, 4'd0, cfield});
        load_in(vals[0]); InPortout = 1; MDR_enable = 1; tick();
        load_in(vals[1]); InPortout = 1; PC_enable = 1; tick();
        load_in(vals[2]); InPortout = 1; Y_enable = 1; tick();
        load_in(vals[3]); InPortout = 1; ZLowIn = 1; ZHighIn = 1; tick();
        load_in(vals[5]); InPortout = 1; LO_enable = 1; tick();
        load_in(vals[6]); InPortout = 1; HI_enable = 1; tick();
        load_in(vals[7]);
        for (int k = 0; k < 10; k++) begin
            for (int j = k; j < 10; j++) set_src(j);
            read_out();
            n_checks++;
            if (out_port !== vals[k]) begin n_err++; $display("FAIL bus_prio src=%0d: got %h want %h", k, out_port, vals[k]); end
        end
        Gra = 1; BAout = 1;
        read_out();
        n_checks++;
        if (out_port !== vals[9]) begin n_err++; $display("FAIL baout_r5: got %h want %h", out_port, vals[9]); end
        read_out();
        n_checks++;
        if (out_port !== 32'd0) begin n_err++; $display("FAIL bus_idle: got %h want 0", out_port); end
        IncPC = 1; PC_enable = 1; InPortout = 1;
        tick();
        PCout = 1;
        read_out();
        n_checks++;
        if (out_port !== vals[1] + 32'd1) begin n_err++; $display("FAIL incpc_prio: got %h want %h", out_port, vals[1] + 32'd1); end
    endtask

    task automatic test_ports();
        logic [31:0] v;
        load_in(32'h55);
        InPortout = 1;
        read_out();
        n_checks++;
        if (out_port !== 32'h55) begin n_err++; $display("FAIL inport: got %h want 55", out_port); end
        write_gpr(4'd2, 32'h1234);
        set_ir({5'b11001, 4'd2, 23'd0});
        Gra = 1; R_out = 1;
        read_out();
        n_checks++;
        if (out_port !== 32'h1234) begin n_err++; $display("FAIL outport_r2: got %h want 1234", out_port); end
        v = $urandom();
        set_ir({5'b11001, 4'd0, 4'd0, 4'd9, 15'd0});
        load_in(v);
        InPortout = 1; Grc = 1; R_in = 1;
        tick();
        set_ir({5'b11001, 4'd1, 4'd8, 4'd0, 15'd0});
        Gra = 1; Grb = 1; R_out = 1;
        read_out();
        n_checks++;
        if (out_port !== v) begin n_err++; $display("FAIL sel_or_r9: got %h want %h", out_port, v); end
    endtask

    initial begin
        clr_ctrl();
        InPort_input = 32'd0;
        Mdatain      = 32'd0;
        Clear        = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Clear = 1'b1;
        test_reset();
        test_ldi();
        test_alu();
        test_mem();
        test_con();
        test_bus_priority();
        test_ports();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
